// File: rtl/unified_memory_arbiter_pkg.sv
// Shared types for the unified memory arbiter.
// Holds FSM state encodings, owner IDs and small helpers.
`ifndef UNIFIED_MEMORY_ARBITER_PKG_SV
`define UNIFIED_MEMORY_ARBITER_PKG_SV
package unified_memory_arbiter_pkg;

   localparam int DEFAULT_ADDRESS_WIDTH  = 32;
   localparam int DEFAULT_DATA_WIDTH     = 32;
   localparam int DEFAULT_MEMORY_LATENCY = 2;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ISSUE   = 2'd1,
      ST_WAIT    = 2'd2,
      ST_RESPOND = 2'd3
   } arb_state_e;

   typedef enum logic {
      OWNER_FETCH = 1'b0,
      OWNER_DATA  = 1'b1
   } owner_e;

   // The port that should win a tie after `o` was last granted.
   function automatic owner_e other_owner(input owner_e o);
      return (o == OWNER_FETCH) ? OWNER_DATA : OWNER_FETCH;
   endfunction

endpackage
`endif

// File: rtl/unified_memory_arbiter_if.sv
// Bus bundle between fetch port, data port, memory and arbiter.
// slave = arbiter view, master = surrounding core/memory view.
interface unified_memory_arbiter_if #(
   parameter int ADDRESS_WIDTH = 32,
   parameter int DATA_WIDTH    = 32
);
   logic                     fetch_request;
   logic [ADDRESS_WIDTH-1:0] fetch_address;
   logic                     fetch_ready;
   logic [DATA_WIDTH-1:0]    fetch_read_data;

   logic                     data_request;
   logic                     data_write_enable;
   logic [ADDRESS_WIDTH-1:0] data_address;
   logic [DATA_WIDTH-1:0]    data_write_data;
   logic                     data_ready;
   logic [DATA_WIDTH-1:0]    data_read_data;

   logic                     memory_enable;
   logic                     memory_write_enable;
   logic [ADDRESS_WIDTH-1:0] memory_address;
   logic [DATA_WIDTH-1:0]    memory_write_data;
   logic [DATA_WIDTH-1:0]    memory_read_data;

   logic                     busy;

   modport slave (
      input  fetch_request,
      input  fetch_address,
      output fetch_ready,
      output fetch_read_data,
      input  data_request,
      input  data_write_enable,
      input  data_address,
      input  data_write_data,
      output data_ready,
      output data_read_data,
      output memory_enable,
      output memory_write_enable,
      output memory_address,
      output memory_write_data,
      input  memory_read_data,
      output busy
   );

   modport master (
      output fetch_request,
      output fetch_address,
      input  fetch_ready,
      input  fetch_read_data,
      output data_request,
      output data_write_enable,
      output data_address,
      output data_write_data,
      input  data_ready,
      input  data_read_data,
      input  memory_enable,
      input  memory_write_enable,
      input  memory_address,
      input  memory_write_data,
      output memory_read_data,
      input  busy
   );
endinterface

// File: rtl/unified_memory_arbiter_grant_select.sv
// Two-way round-robin picker for the unified memory arbiter.
// A sole requester wins; a tie goes opposite the last grant.
module memory_grant_select
   import unified_memory_arbiter_pkg::*;
(
   input  logic   fetch_request,
   input  logic   data_request,
   input  owner_e last_grant,
   output logic   grant_valid,
   output owner_e grant_owner
);

   // Pick the winner from the current requests and last grant.
   always_comb begin
      grant_valid = fetch_request | data_request;
      grant_owner = OWNER_FETCH;
      unique case (1'b1)
         (fetch_request & ~data_request): grant_owner = OWNER_FETCH;
         (data_request & ~fetch_request): grant_owner = OWNER_DATA;
         (fetch_request & data_request):  grant_owner = other_owner(last_grant);
         default:                         grant_owner = OWNER_FETCH;
      endcase
   end

endmodule

// File: rtl/unified_memory_arbiter.sv
// Unified memory arbiter: shares one fixed-latency memory between
// instruction fetch (read-only) and load/store (read/write) ports.
module unified_memory_arbiter
   import unified_memory_arbiter_pkg::*;
#(
   parameter int ADDRESS_WIDTH  = DEFAULT_ADDRESS_WIDTH,
   parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
   parameter int MEMORY_LATENCY = DEFAULT_MEMORY_LATENCY
) (
   input logic                    system_clock,
   input logic                    reset,
   unified_memory_arbiter_if.slave bus
);

   localparam int CW = $clog2(MEMORY_LATENCY + 1);
   typedef logic [CW-1:0] cnt_t;
   localparam cnt_t CNT_LOAD = cnt_t'(MEMORY_LATENCY - 1);

   if (MEMORY_LATENCY < 1) begin : g_bad_latency
      $error("MEMORY_LATENCY must be at least 1");
   end

   arb_state_e               state_q, state_d;
   cnt_t                     cnt_q, cnt_d;
   owner_e                   last_q, last_d;
   owner_e                   owner_q, owner_d;
   logic                     is_write_q, is_write_d;

   logic                     men_q, men_d;
   logic                     mwe_q, mwe_d;
   logic [ADDRESS_WIDTH-1:0] maddr_q, maddr_d;
   logic [DATA_WIDTH-1:0]    mwdata_q, mwdata_d;

   logic                     fready_q, fready_d;
   logic                     dready_q, dready_d;
   logic [DATA_WIDTH-1:0]    frd_q, frd_d;
   logic [DATA_WIDTH-1:0]    drd_q, drd_d;
   logic                     busy_q, busy_d;

   logic                     grant_valid;
   owner_e                   grant_owner;

   memory_grant_select u_grant (
      .fetch_request (bus.fetch_request),
      .data_request  (bus.data_request),
      .last_grant    (last_q),
      .grant_valid   (grant_valid),
      .grant_owner   (grant_owner)
   );

   // State register plus every registered output and payload latch.
   always_ff @(posedge system_clock or posedge reset) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         last_q     <= OWNER_DATA;
         owner_q    <= OWNER_FETCH;
         is_write_q <= 1'b0;
         men_q      <= 1'b0;
         mwe_q      <= 1'b0;
         maddr_q    <= '0;
         mwdata_q   <= '0;
         fready_q   <= 1'b0;
         dready_q   <= 1'b0;
         frd_q      <= '0;
         drd_q      <= '0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         last_q     <= last_d;
         owner_q    <= owner_d;
         is_write_q <= is_write_d;
         men_q      <= men_d;
         mwe_q      <= mwe_d;
         maddr_q    <= maddr_d;
         mwdata_q   <= mwdata_d;
         fready_q   <= fready_d;
         dready_q   <= dready_d;
         frd_q      <= frd_d;
         drd_q      <= drd_d;
         busy_q     <= busy_d;
      end
   end

   // Next-state and next-output logic; memory strobe and ready
   // pulses default low so they last exactly one cycle.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      last_d     = last_q;
      owner_d    = owner_q;
      is_write_d = is_write_q;
      men_d      = 1'b0;
      mwe_d      = 1'b0;
      maddr_d    = '0;
      mwdata_d   = '0;
      fready_d   = 1'b0;
      dready_d   = 1'b0;
      frd_d      = frd_q;
      drd_d      = drd_q;

      unique case (state_q)
         ST_IDLE: begin
            if (grant_valid) begin
               state_d = ST_ISSUE;
               owner_d = grant_owner;
               last_d  = grant_owner;
               men_d   = 1'b1;
               if (grant_owner == OWNER_FETCH) begin
                  maddr_d = bus.fetch_address;
               end else begin
                  maddr_d  = bus.data_address;
                  mwe_d    = bus.data_write_enable;
                  mwdata_d = bus.data_write_data;
               end
               is_write_d = mwe_d;
            end
         end
         ST_ISSUE: begin
            cnt_d   = CNT_LOAD;
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (cnt_q == '0) begin
               state_d = ST_RESPOND;
               if (owner_q == OWNER_FETCH) begin
                  fready_d = 1'b1;
                  if (!is_write_q) frd_d = bus.memory_read_data;
               end else begin
                  dready_d = 1'b1;
                  if (!is_write_q) drd_d = bus.memory_read_data;
               end
            end else begin
               cnt_d = cnt_q - cnt_t'(1);
            end
         end
         ST_RESPOND: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   assign bus.memory_enable       = men_q;
   assign bus.memory_write_enable = mwe_q;
   assign bus.memory_address      = maddr_q;
   assign bus.memory_write_data   = mwdata_q;
   assign bus.fetch_ready         = fready_q;
   assign bus.fetch_read_data     = frd_q;
   assign bus.data_ready          = dready_q;
   assign bus.data_read_data      = drd_q;
   assign bus.busy                = busy_q;

endmodule

// File: tb/tb_unified_memory_arbiter.sv
// Self-checking bench for unified_memory_arbiter.
// Transaction-level model plus directed literal checks.
module tb_unified_memory_arbiter;

   localparam int LAT = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic rst1 = 1'b1;

   initial forever #5 clk = ~clk;

   unified_memory_arbiter_if #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) m0 ();
   unified_memory_arbiter_if #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) m1 ();

   unified_memory_arbiter #(
      .ADDRESS_WIDTH(32), .DATA_WIDTH(32), .MEMORY_LATENCY(LAT)
   ) dut0 (
      .system_clock(clk), .reset(rst), .bus(m0)
   );

   unified_memory_arbiter #(
      .ADDRESS_WIDTH(32), .DATA_WIDTH(32), .MEMORY_LATENCY(1)
   ) dut1 (
      .system_clock(clk), .reset(rst1), .bus(m1)
   );

   int n_chk = 0;
   int n_fail = 0;
   int cyc = 0;

   bit          have_txn;
   int          t0;
   bit          m_own;
   bit          m_we;
   bit          last_g;
   logic [31:0] m_addr, m_wd, m_rv;
   logic [31:0] exp_frd, exp_drd;
   logic [31:0] mem [logic [31:0]];

   bit f_act, d_act;

   task automatic chk1(input string nm, input logic act, input logic exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s cyc=%0d got=%b exp=%b", nm, cyc, act, exp);
      end
   endtask

   task automatic chk32(input string nm, input logic [31:0] act,
                        input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, act, exp);
      end
   endtask

   function automatic logic [31:0] mem_rd(input logic [31:0] a);
      if (mem.exists(a)) return mem[a];
      return a ^ 32'hA5C3_0F96;
   endfunction

   task automatic model_reset();
      have_txn = 0;
      exp_frd  = '0;
      exp_drd  = '0;
      last_g   = 1'b1;
   endtask

   // Compare DUT outputs against where the model's transaction is.
   task automatic compare();
      int off;
      bit e_busy, e_men, e_fr, e_dr;
      off = have_txn ? (cyc - t0) : -1;
      if (off == 2 + LAT && !m_we) begin
         if (m_own) exp_drd = m_rv;
         else       exp_frd = m_rv;
      end
      e_busy = (off >= 1) && (off <= 2 + LAT);
      e_men  = (off == 1);
      e_fr   = (off == 2 + LAT) && !m_own;
      e_dr   = (off == 2 + LAT) && m_own;
      chk1("busy", m0.busy, e_busy);
      chk1("mem_en", m0.memory_enable, e_men);
      chk1("f_ready", m0.fetch_ready, e_fr);
      chk1("d_ready", m0.data_ready, e_dr);
      chk32("f_rdata", m0.fetch_read_data, exp_frd);
      chk32("d_rdata", m0.data_read_data, exp_drd);
      if (e_men && m0.memory_enable) begin
         chk32("mem_addr", m0.memory_address, m_addr);
         chk1("mem_we", m0.memory_write_enable, m_we);
         if (m_we) chk32("mem_wdata", m0.memory_write_data, m_wd);
      end
   endtask

   // Drive memory read data and make grant decisions for this cycle.
   task automatic commit();
      int off;
      off = have_txn ? (cyc - t0) : -1;
      if (off == 1 + LAT) m0.memory_read_data = m_rv;
      else                m0.memory_read_data = $urandom;
      if (!rst && (!have_txn || off >= 3 + LAT) &&
          (m0.fetch_request || m0.data_request)) begin
         have_txn = 1;
         t0 = cyc;
         if (m0.fetch_request && m0.data_request) m_own = !last_g;
         else m_own = m0.data_request;
         last_g = m_own;
         m_addr = m_own ? m0.data_address : m0.fetch_address;
         m_we   = m_own && m0.data_write_enable;
         m_wd   = m0.data_write_data;
         m_rv   = mem_rd(m_addr);
         if (m_we) mem[m_addr] = m_wd;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      compare();
   endtask

   task automatic step(input int n);
      repeat (n) begin
         tick();
         commit();
      end
   endtask

   function automatic logic [31:0] rnd_addr();
      return 32'($urandom_range(0, 15)) << 2;
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      model_reset();
      m0.fetch_request = 0; m0.fetch_address = '0;
      m0.data_request = 0; m0.data_write_enable = 0;
      m0.data_address = '0; m0.data_write_data = '0;
      m0.memory_read_data = '0;
      m1.fetch_request = 0; m1.fetch_address = '0;
      m1.data_request = 0; m1.data_write_enable = 0;
      m1.data_address = '0; m1.data_write_data = '0;
      m1.memory_read_data = 32'hFFFF_FFFF;
      f_act = 0; d_act = 0;

      // Reset state
      step(2);
      chk1("rst_busy", m0.busy, 1'b0);
      chk1("rst_men", m0.memory_enable, 1'b0);
      chk32("rst_maddr", m0.memory_address, 32'h0);
      chk1("rst_fready", m0.fetch_ready, 1'b0);
      tick();
      rst = 0; rst1 = 0;
      commit();
      step(1);

      // Fetch read of 0x40
      tick();
      m0.fetch_request = 1; m0.fetch_address = 32'h40;
      mem[32'h40] = 32'h8C01_0004;
      commit();
      tick();
      chk1("t2_men", m0.memory_enable, 1'b1);
      chk32("t2_addr", m0.memory_address, 32'h40);
      chk1("t2_we", m0.memory_write_enable, 1'b0);
      commit();
      step(2);
      tick();
      chk1("t2_fready", m0.fetch_ready, 1'b1);
      chk32("t2_frd", m0.fetch_read_data, 32'h8C01_0004);
      chk1("t2_dready", m0.data_ready, 1'b0);
      m0.fetch_request = 0;
      commit();
      step(1);

      // Data write of 0xDEADBEEF to 0x100
      tick();
      m0.data_request = 1; m0.data_write_enable = 1;
      m0.data_address = 32'h100; m0.data_write_data = 32'hDEAD_BEEF;
      commit();
      tick();
      chk1("t3_men", m0.memory_enable, 1'b1);
      chk1("t3_we", m0.memory_write_enable, 1'b1);
      chk32("t3_wd", m0.memory_write_data, 32'hDEAD_BEEF);
      commit();
      step(2);
      tick();
      chk1("t3_dready", m0.data_ready, 1'b1);
      chk32("t3_drd", m0.data_read_data, 32'h0);
      m0.data_request = 0; m0.data_write_enable = 0;
      commit();
      step(1);

      // Continuous dual requests after reset alternate F, D, F
      tick();
      rst = 1;
      model_reset();
      commit();
      tick();
      rst = 0;
      m0.fetch_request = 1; m0.fetch_address = 32'h200;
      m0.data_request = 1; m0.data_address = 32'h300;
      commit();
      for (int r = 1; r <= 14; r++) begin
         tick();
         chk1("t4_men", m0.memory_enable, (r == 1 || r == 6 || r == 11));
         chk1("t4_fready", m0.fetch_ready, (r == 4 || r == 14));
         chk1("t4_dready", m0.data_ready, (r == 9));
         if (r == 14) begin
            m0.fetch_request = 0;
            m0.data_request = 0;
         end
         commit();
      end
      step(2);

      // Reset during WAIT of a fetch
      tick();
      m0.fetch_request = 1; m0.fetch_address = 32'h80;
      commit();
      step(2);
      rst = 1;
      model_reset();
      #1;
      chk1("t5_busy", m0.busy, 1'b0);
      chk1("t5_fready", m0.fetch_ready, 1'b0);
      chk32("t5_frd", m0.fetch_read_data, 32'h0);
      tick();
      rst = 0;
      commit();
      tick();
      chk1("t5_reissue", m0.memory_enable, 1'b1);
      chk32("t5_addr", m0.memory_address, 32'h80);
      commit();
      step(2);
      tick();
      chk1("t5_fready2", m0.fetch_ready, 1'b1);
      m0.fetch_request = 0;
      commit();
      step(1);

      // Randomized traffic with occasional reset
      for (int i = 0; i < 3000; i++) begin
         tick();
         if (rst) rst = 0;
         if (m0.fetch_ready) begin
            f_act = 0;
            m0.fetch_request = 0;
         end else if (f_act && have_txn && !m_own && cyc > t0 &&
                      $urandom_range(0, 9) == 0) begin
            m0.fetch_request = 0;
            m0.fetch_address = $urandom;
         end
         if (!f_act && $urandom_range(0, 2) == 0) begin
            f_act = 1;
            m0.fetch_request = 1;
            m0.fetch_address = rnd_addr();
         end
         if (m0.data_ready) begin
            d_act = 0;
            m0.data_request = 0;
         end else if (d_act && have_txn && m_own && cyc > t0 &&
                      $urandom_range(0, 9) == 0) begin
            m0.data_request = 0;
            m0.data_address = $urandom;
            m0.data_write_data = $urandom;
            m0.data_write_enable = $urandom_range(0, 1) == 1;
         end
         if (!d_act && $urandom_range(0, 2) == 0) begin
            d_act = 1;
            m0.data_request = 1;
            m0.data_address = rnd_addr();
            m0.data_write_enable = $urandom_range(0, 1) == 1;
            m0.data_write_data = $urandom;
         end
         if ($urandom_range(0, 299) == 0) begin
            rst = 1;
            model_reset();
            f_act = m0.fetch_request;
            d_act = m0.data_request;
         end
         commit();
      end
      tick();
      rst = 0;
      m0.fetch_request = 0;
      m0.data_request = 0;
      commit();

      // Latency-1 instance: data read of 0x20
      tick();
      m1.data_request = 1; m1.data_write_enable = 0;
      m1.data_address = 32'h20;
      commit();
      tick();
      chk1("l1_men", m1.memory_enable, 1'b1);
      chk32("l1_addr", m1.memory_address, 32'h20);
      chk1("l1_we", m1.memory_write_enable, 1'b0);
      commit();
      tick();
      chk1("l1_dready_early", m1.data_ready, 1'b0);
      m1.memory_read_data = 32'h1234_5678;
      commit();
      tick();
      chk1("l1_dready", m1.data_ready, 1'b1);
      chk32("l1_drd", m1.data_read_data, 32'h1234_5678);
      m1.data_request = 0;
      m1.memory_read_data = 32'hFFFF_FFFF;
      commit();
      tick();
      chk1("l1_pulse", m1.data_ready, 1'b0);
      chk32("l1_hold", m1.data_read_data, 32'h1234_5678);
      chk1("l1_fready", m1.fetch_ready, 1'b0);
      commit();

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/unified_memory_arbiter.md
Name: unified_memory_arbiter

Overview:
Shares one single-ported, fixed-latency memory between two requesters: the instruction fetch port (read-only) and the load/store data port (read/write). It arbitrates round-robin, issues one transaction at a time to the memory, waits the configured latency, then returns a one-cycle ready pulse with registered read data. It sits between instruction_fetch_unit, the MEM stage and the backing memory, so the core can move to a unified memory.

Parameters:
ADDRESS_WIDTH, 32, width of all address buses
DATA_WIDTH, 32, width of all data buses
MEMORY_LATENCY, 2, cycles from the issue cycle to valid memory_read_data; legal range >= 1

Ports:
system_clock  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
fetch_request  input  1  fetch port requests a read; held until fetch_ready
fetch_address  input  ADDRESS_WIDTH  fetch read address; stable while requesting
fetch_ready  output  1  one-cycle pulse; fetch transaction complete
fetch_read_data  output  DATA_WIDTH  fetch read data; valid with fetch_ready, held afterwards
data_request  input  1  data port requests an access; held until data_ready
data_write_enable  input  1  1 = write, 0 = read
data_address  input  ADDRESS_WIDTH  data access address
data_write_data  input  DATA_WIDTH  store data
data_ready  output  1  one-cycle pulse; data transaction complete
data_read_data  output  DATA_WIDTH  load data; updated only on reads
memory_enable  output  1  one-cycle issue strobe to memory
memory_write_enable  output  1  write qualifier; meaningful only with memory_enable
memory_address  output  ADDRESS_WIDTH  issued address
memory_write_data  output  DATA_WIDTH  issued write data
memory_read_data  input  DATA_WIDTH  memory read data
busy  output  1  high in every state except IDLE

Behaviour:
- All outputs are registered. Reset (asynchronous, active-high) forces state IDLE, all outputs 0, latency counter 0 and last_grant to DATA.
- FSM states: IDLE, ISSUE, WAIT, RESPOND.
- IDLE: with no request, stay in IDLE. With any request, pick a winner and latch owner, address, write enable and write data, then go to ISSUE.
- Arbitration: a sole requester wins. On a tie, the winner is the port opposite last_grant. last_grant updates only when a grant is made. After reset the first tie therefore goes to FETCH. Continuous dual requests alternate F, D, F, D.
- A fetch grant always issues a read. memory_write_enable is forced 0 for fetch transactions.
- ISSUE (1 cycle): memory_enable=1 and the latched address, write enable and data are driven. The counter loads MEMORY_LATENCY-1. Next state is WAIT.
- WAIT: the counter decrements each cycle. In the cycle where the counter is 0, memory_read_data is valid. The arbiter captures it into the owner's read-data register (reads only) and goes to RESPOND. memory_enable=0 throughout WAIT.
- RESPOND (1 cycle): the owner's ready output is 1 and the other ready output is 0. Next state is IDLE.
- Timing, with a request first seen in IDLE at cycle 0: issue in cycle 1, read data valid in cycle 1+MEMORY_LATENCY, ready in cycle 2+MEMORY_LATENCY. With default parameters, ready is in cycle 4.
- Requests are sampled only in IDLE. A request still high in the IDLE cycle after RESPOND is a new transaction.
- Read-data outputs hold their last value between transactions. Writes do not alter data_read_data.
- Request dropped mid-transaction: the transaction still completes and ready still pulses.
- Request inputs and payloads changing after grant are ignored, because the payload is latched in IDLE.
- Reset mid-transaction: the transaction is abandoned immediately, no ready pulse is produced, and a write already issued is not retracted. After reset releases, held requests are re-arbitrated from IDLE.
- Addresses pass through unmodified; no alignment checks are made.
- Counter width is $clog2(MEMORY_LATENCY+1).

Decomposition:
- Shared header file (include-guarded) holding the state encodings (IDLE, ISSUE, WAIT, RESPOND) and the owner IDs (OWNER_FETCH=0, OWNER_DATA=1).
- One sub-module, memory_grant_select: combinational 2-way round-robin picker. Inputs are fetch_request, data_request and last_grant; outputs are grant_valid and grant_owner.

Test Plan:
1. Assert then release reset -> all outputs 0, busy=0; a tie afterwards grants fetch first.
2. Fetch read 0x00000040, with memory returning 0x8C010004 in cycle 3 -> memory_enable=1 with address 0x40 and we=0 in cycle 1; fetch_ready=1 with fetch_read_data=0x8C010004 in cycle 4; data_ready stays 0.
3. Data write to 0x100 with 0xDEADBEEF -> cycle 1 has memory_enable=1, memory_write_enable=1 and memory_write_data=0xDEADBEEF; data_ready in cycle 4; data_read_data unchanged.
4. Both ports requesting continuously after reset -> issues in cycles 1 (F), 6 (D), 11 (F); ready pulses in cycles 4, 9, 14.
5. Reset asserted during WAIT (cycle 2) of a fetch -> outputs go to 0 immediately and no fetch_ready appears. After release, the held fetch_request is re-issued 1 cycle later.
6. MEMORY_LATENCY=1 with a data read at 0x20 returning 0x12345678 -> issue in cycle 1, data_ready=1 with data_read_data=0x12345678 in cycle 3.
